// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to main memory and
// presents each returned word to decode; redirects squash in-flight fetches.
module fetch_unit #(
  parameter int                      ADDRESS_SIZE = 32,
  parameter int                      DATA_SIZE    = 32,
  parameter int                      ACCESS_SIZE  = 2,
  parameter logic [ADDRESS_SIZE-1:0] START_ADDR   = 32'h8002_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic                    mem_en,
  output logic                    mem_wren,
  output logic [ACCESS_SIZE-1:0]  mem_acc_size,
  input  logic                    mem_busy,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [ADDRESS_SIZE-1:0] redirect_pc,
  output logic [DATA_SIZE-1:0]    insn,
  output logic [ADDRESS_SIZE-1:0] insn_pc,
  output logic                    insn_valid
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
  logic                    squash_q, squash_d;
  logic [DATA_SIZE-1:0]    insn_q, insn_d;
  logic [ADDRESS_SIZE-1:0] insn_pc_q, insn_pc_d;
  logic                    insn_valid_q, insn_valid_d;
  logic [ADDRESS_SIZE-1:0] redirect_tgt;

  // Targets are word aligned; the low address bits from downstream are dropped.
  assign redirect_tgt = {redirect_pc[ADDRESS_SIZE-1:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    squash_d     = squash_q;
    insn_d       = insn_q;
    insn_pc_d    = insn_pc_q;
    insn_valid_d = insn_valid_q;
    case (state_q)
      S_RESET: state_d = S_ISSUE;
      S_ISSUE: begin
        if (!mem_busy) state_d = S_WAIT;
        if (redirect) begin
          pc_d = redirect_tgt;
          // The request just accepted is for the old PC and must be dropped.
          if (!mem_busy) squash_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect) pc_d = redirect_tgt;
        if (!mem_busy) begin
          if (squash_q || redirect) begin
            squash_d = 1'b0;
            state_d  = S_ISSUE;
          end else begin
            insn_d       = mem_d_out;
            insn_pc_d    = pc_q;
            insn_valid_d = 1'b1;
            state_d      = S_VALID;
          end
        end else if (redirect) begin
          squash_d = 1'b1;
        end
      end
      S_VALID: begin
        if (redirect) begin
          pc_d         = redirect_tgt;
          insn_valid_d = 1'b0;
          state_d      = S_ISSUE;
        end else if (!stall) begin
          pc_d         = pc_q + ADDRESS_SIZE'(4);
          insn_valid_d = 1'b0;
          state_d      = S_ISSUE;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      pc_q         <= START_ADDR;
      squash_q     <= 1'b0;
      insn_q       <= '0;
      insn_pc_q    <= '0;
      insn_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      squash_q     <= squash_d;
      insn_q       <= insn_d;
      insn_pc_q    <= insn_pc_d;
      insn_valid_q <= insn_valid_d;
    end
  end

  // Memory request decoded from registered state only.
  assign mem_en       = (state_q == S_ISSUE);
  assign mem_addr     = (state_q == S_ISSUE) ? pc_q : '0;
  assign mem_wren     = 1'b0;
  assign mem_acc_size = ACCESS_SIZE'(2'b10);

  assign insn       = insn_q;
  assign insn_pc    = insn_pc_q;
  assign insn_valid = insn_valid_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the main memory model. It owns the program counter and issues word-sized read requests on the memory's request port, honouring its `busy` handshake. It captures each returned word and hands it to decode with a valid/stall handshake. Branch redirects from downstream squash in-flight fetches and restart at the target.

## Interface
- `START_ADDR`, 32'h8002_0000, PC value loaded on reset
- `ADDRESS_SIZE`, 32, address/PC width
- `DATA_SIZE`, 32, instruction width
- `ACCESS_SIZE`, 2, width of memory access-size code
- `clk` in 1: single clock; all state changes on rising edge
- `rst` in 1: synchronous, active-high reset
- `mem_addr` out ADDRESS_SIZE: request address to main memory
- `mem_en` out 1: request strobe to main memory
- `mem_wren` out 1: tied 0 (fetch never writes)
- `mem_acc_size` out ACCESS_SIZE: constant 2'b10 (word)
- `mem_busy` in 1: memory busy; request not accepted, data not ready
- `mem_d_out` in DATA_SIZE: read data from memory
- `stall` in 1: decode cannot accept the presented instruction
- `redirect` in 1: branch/jump taken, one-cycle pulse
- `redirect_pc` in ADDRESS_SIZE: redirect target
- `insn` out DATA_SIZE: fetched instruction
- `insn_pc` out ADDRESS_SIZE: address of `insn`
- `insn_valid` out 1: `insn`/`insn_pc` valid for decode

## Operation
- States: RESET, ISSUE, WAIT, VALID. Registers: `pc`, `squash`, `insn`, `insn_pc`, `insn_valid`.
- Reset (any cycle, any state): state=RESET, `pc`=START_ADDR, `squash`=0, `insn`=0, `insn_pc`=0, `insn_valid`=0, `mem_en`=0, `mem_addr`=0. RESET → ISSUE on first cycle with `rst`=0.
- ISSUE: `mem_en`=1, `mem_addr`=`pc`. If `mem_busy`=1, stay in ISSUE (request not accepted). If `mem_busy`=0, request accepted at this edge → WAIT.
- WAIT: `mem_en`=0. While `mem_busy`=1 stay. First cycle with `mem_busy`=0: `mem_d_out` is the data. If `squash`=0: capture `insn`←`mem_d_out`, `insn_pc`←`pc`, `insn_valid`←1 → VALID. If `squash`=1: discard data, clear `squash` → ISSUE.
- VALID: `insn_valid`=1 held stable. `stall`=1: hold everything. `stall`=0: instruction consumed this edge; `insn_valid`←0, `pc`←`pc`+4 → ISSUE.
- PC arithmetic: modulo 2^ADDRESS_SIZE; 32'hFFFF_FFFC + 4 wraps to 0. `redirect_pc[1:0]` ignored, loaded as 2'b00.
- Redirect (priority over `stall`, below `rst`): `pc`←{`redirect_pc`[31:2],2'b00}.
  - In ISSUE with `mem_busy`=0 (request accepted same edge): → WAIT with `squash`=1.
  - In ISSUE with `mem_busy`=1: → ISSUE, new `pc` presented next cycle.
  - In WAIT: `squash`←1 (if data returns this same cycle it is discarded, → ISSUE).
  - In VALID: `insn_valid`←0 regardless of `stall` → ISSUE.
  - In RESET: ignored.
- A second redirect while `squash`=1 only updates `pc`; exactly one response is discarded.

## Timing
- All outputs registered or decoded from registered state; no combinational path from `stall`/`redirect` to memory outputs.
- Zero-busy fetch: ISSUE cycle N, WAIT cycle N+1 (data returned), `insn_valid`=1 cycle N+2. Throughput with `stall`=0: one instruction per 3 cycles.
- Each cycle of `mem_busy`=1 in ISSUE or WAIT adds one cycle.
- Redirect in VALID at cycle N: ISSUE at target in N+1, `insn_valid` at N+3 (zero busy).
- `insn`/`insn_pc` may change only on the edge entering VALID.

## Test plan
- Reset release, memory words 0x11,0x22,0x33 at 0x80020000/4/8, `mem_busy`=0, `stall`=0 -> `insn_valid` pulses every 3 cycles with `insn_pc` 0x80020000, 0x80020004, 0x80020008 and matching data; `mem_acc_size`=2'b10, `mem_wren`=0 throughout.
- `mem_busy` high 2 cycles in ISSUE and 3 cycles in WAIT -> `mem_en`/`mem_addr` held in ISSUE, instruction appears 5 cycles later than zero-busy case, data correct.
- `stall` held 4 cycles in VALID -> `insn`, `insn_pc`, `insn_valid` stable; next ISSUE at `pc`+4 only after `stall` drops.
- `redirect` to 0x80021003 while WAIT with `mem_busy`=1 -> returned word discarded (no `insn_valid`), next ISSUE at 0x80021000, delivered `insn_pc`=0x80021000.
- `redirect` with `stall`=1 in VALID -> `insn_valid` drops next cycle, fetch at target; redirect coincident with accepted ISSUE -> exactly one response squashed.
- `rst` asserted in WAIT and in VALID; `pc`=0xFFFFFFFC advance -> all outputs zero during reset, refetch from START_ADDR; PC wraps to 0x00000000.
